// File: rtl/clk_div_pkg.sv
// Shared constants and divisor helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DIV_W_DEF = 16;
  localparam logic [31:0] MIN_DIV = 32'd2;

  // Divisors below MIN_DIV cannot produce both a low and a high phase.
  function automatic logic [31:0] clamp_div(input logic [31:0] value);
    logic [31:0] res;
    if (value < MIN_DIV) begin
      res = MIN_DIV;
    end else begin
      res = value;
    end
    return res;
  endfunction

  function automatic logic [31:0] half_ceil(input logic [31:0] value);
    return (value >> 1) + {31'd0, value[0]};
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, shadow/active divisor, registered clk_o and tick_o.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk_in_50M,
  input  logic             rst_n,
  input  logic             sync_i,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] shd_q, shd_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] div_cur_s;
  logic [DIV_W-1:0] div_nxt_s;
  logic             wrap_s;

  // Next-state logic; the active divisor only changes at a wrap or sync edge.
  always_comb begin
    shd_d     = load ? div_i : shd_q;
    act_d     = act_q;
    cnt_d     = cnt_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    div_cur_s = DIV_W'(clamp_div(32'(act_q)));
    wrap_s    = (cnt_q == (div_cur_s - DIV_W'(1)));
    div_nxt_s = div_cur_s;
    if (sync_i) begin
      act_d = shd_d;
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (en) begin
      if (wrap_s) begin
        act_d = shd_d;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      div_nxt_s = DIV_W'(clamp_div(32'(act_d)));
      clk_d     = (cnt_d >= DIV_W'(half_ceil(32'(div_nxt_s))));
      tick_d    = (cnt_d == (div_nxt_s - DIV_W'(1)));
    end else begin
      clk_d = clk_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_in_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      act_q  <= DIV_W'(DEFAULT_DIV);
      shd_q  <= DIV_W'(DEFAULT_DIV);
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_divider_multi.sv
// N-channel programmable clock divider with per-channel clock and tick outputs.
// Optional macro CLK_DIV_SYNC_EN adds the sync_i phase-alignment input.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 10
) (
  input  logic                      clk_in_50M,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*DIV_W-1:0] div_i,
  output logic [CHANNELS-1:0]       clk_o,
  output logic [CHANNELS-1:0]       tick_o
`ifdef CLK_DIV_SYNC_EN
  ,
  input  logic                      sync_i
`endif
);

  logic sync_s;

`ifdef CLK_DIV_SYNC_EN
  assign sync_s = sync_i;
`else
  assign sync_s = 1'b0;
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    clk_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in_50M (clk_in_50M),
      .rst_n      (rst_n),
      .sync_i     (sync_s),
      .en         (en[k]),
      .load       (load[k]),
      .div_i      (div_i[k*DIV_W +: DIV_W]),
      .clk_o      (clk_o[k]),
      .tick_o     (tick_o[k])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed self-checking bench for clk_divider_multi (3 channels, 16-bit divisors).
module tb_clk_divider_multi;

  logic        clk_in_50M;
  logic        rst_n;
  logic [2:0]  en;
  logic [2:0]  load;
  logic [47:0] div_i;
  logic [2:0]  clk_o;
  logic [2:0]  tick_o;
`ifdef CLK_DIV_SYNC_EN
  logic        sync_i;
`endif

  int tests;
  int failed;

  typedef struct {
    logic [15:0] div;
    int          exp_low;
    int          exp_high;
  } vec_t;

  vec_t vecs[6];

  clk_divider_multi dut (
    .clk_in_50M (clk_in_50M),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .div_i      (div_i),
    .clk_o      (clk_o),
    .tick_o     (tick_o)
`ifdef CLK_DIV_SYNC_EN
    ,
    .sync_i     (sync_i)
`endif
  );

  initial clk_in_50M = 1'b0;
  always #10 clk_in_50M = ~clk_in_50M;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_in_50M);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick(input int ch, input string name);
    for (int i = 0; i < 64 && tick_o[ch] !== 1'b1; i++) step();
    check(name, 32'(tick_o[ch]), 32'd1);
  endtask

  initial begin
    int lows, highs, ticks, k;
    logic last;
    int dch[3];

    tests  = 0;
    failed = 0;
    vecs[0] = '{div: 16'd0,  exp_low: 1, exp_high: 1};
    vecs[1] = '{div: 16'd1,  exp_low: 1, exp_high: 1};
    vecs[2] = '{div: 16'd2,  exp_low: 1, exp_high: 1};
    vecs[3] = '{div: 16'd7,  exp_low: 4, exp_high: 3};
    vecs[4] = '{div: 16'd10, exp_low: 5, exp_high: 5};
    vecs[5] = '{div: 16'd3,  exp_low: 2, exp_high: 1};

    rst_n = 1'b1;
    en    = 3'b111;
    load  = 3'b000;
    div_i = 48'd0;
`ifdef CLK_DIV_SYNC_EN
    sync_i = 1'b0;
`endif
    #2 rst_n = 1'b0;
    step();
    step();
    check("reset_clk", 32'(clk_o), 32'd0);
    check("reset_tick", 32'(tick_o), 32'd0);
    rst_n = 1'b1;

    // Default divide-by-10 on every channel
    for (int c = 1; c <= 40; c++) begin
      step();
      k = c % 10;
      check($sformatf("def_clk_c%0d", c), 32'(clk_o), (k >= 5) ? 32'd7 : 32'd0);
      check($sformatf("def_tick_c%0d", c), 32'(tick_o), (k == 9) ? 32'd7 : 32'd0);
    end

    // Channel 0: load D=3 at cnt=4, current period must finish first
    for (int i = 0; i < 4; i++) step();
    load[0] = 1'b1;
    div_i[15:0] = 16'd3;
    step();
    load[0] = 1'b0;
    check("ld3_cnt5_clk", 32'(clk_o[0]), 32'd1);
    for (int i = 0; i < 4; i++) step();
    check("ld3_cnt9_tick", 32'(tick_o[0]), 32'd1);
    check("ld3_cnt9_clk", 32'(clk_o[0]), 32'd1);
    step();
    check("ld3_wrap_clk", 32'(clk_o[0]), 32'd0);
    check("ld3_wrap_tick", 32'(tick_o[0]), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      step();
      k = i % 3;
      check($sformatf("d3_clk_%0d", i), 32'(clk_o[0]), (k == 2) ? 32'd1 : 32'd0);
      check($sformatf("d3_tick_%0d", i), 32'(tick_o[0]), (k == 2) ? 32'd1 : 32'd0);
    end
    check("ch1_indep_tick", 32'(tick_o[1]), 32'd1);

    // Channel 2: table of divisors, one full period measured after each wrap
    for (int v = 0; v < 6; v++) begin
      load[2] = 1'b1;
      div_i[47:32] = vecs[v].div;
      step();
      load[2] = 1'b0;
      wait_tick(2, $sformatf("vec%0d_tick_wait", v));
      step();
      lows = 0; highs = 0; ticks = 0; last = 1'b0;
      for (int j = 0; j < vecs[v].exp_low + vecs[v].exp_high; j++) begin
        if (clk_o[2]) highs++;
        else lows++;
        if (tick_o[2]) ticks++;
        last = tick_o[2];
        step();
      end
      check($sformatf("vec%0d_low", v), 32'(lows), 32'(vecs[v].exp_low));
      check($sformatf("vec%0d_high", v), 32'(highs), 32'(vecs[v].exp_high));
      check($sformatf("vec%0d_ticks", v), 32'(ticks), 32'd1);
      check($sformatf("vec%0d_tick_last", v), 32'(last), 32'd1);
    end

    // Load landing on the wrap edge takes effect immediately
    wait_tick(2, "byp_tick_wait");
    load[2] = 1'b1;
    div_i[47:32] = 16'd4;
    step();
    load[2] = 1'b0;
    check("byp_wrap_clk", 32'(clk_o[2]), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      k = i % 4;
      check($sformatf("byp_clk_%0d", i), 32'(clk_o[2]), (k >= 2) ? 32'd1 : 32'd0);
      check($sformatf("byp_tick_%0d", i), 32'(tick_o[2]), (k == 3) ? 32'd1 : 32'd0);
    end

    // Channel 1: hold at cnt=9 for 6 cycles
    wait_tick(1, "hold_tick_wait");
    en[1] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("hold_clk_%0d", i), 32'(clk_o[1]), 32'd1);
      check($sformatf("hold_tick_%0d", i), 32'(tick_o[1]), 32'd0);
    end
    en[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      k = (9 + i) % 10;
      check($sformatf("resume_clk_%0d", i), 32'(clk_o[1]), (k >= 5) ? 32'd1 : 32'd0);
      check($sformatf("resume_tick_%0d", i), 32'(tick_o[1]), (k == 9) ? 32'd1 : 32'd0);
    end

    // Channel 0: reset mid-period with a pending shadow value
    wait_tick(0, "rst_tick_wait");
    step();
    load[0] = 1'b1;
    div_i[15:0] = 16'd5;
    step();
    load[0] = 1'b0;
    step();
    check("pre_rst_clk0", 32'(clk_o[0]), 32'd1);
    #4 rst_n = 1'b0;
    #1;
    check("async_rst_clk", 32'(clk_o), 32'd0);
    check("async_rst_tick", 32'(tick_o), 32'd0);
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      k = e % 10;
      check($sformatf("post_rst_clk_%0d", e), 32'(clk_o), (k >= 5) ? 32'd7 : 32'd0);
      check($sformatf("post_rst_tick_%0d", e), 32'(tick_o), (k == 9) ? 32'd7 : 32'd0);
    end

`ifdef CLK_DIV_SYNC_EN
    // Phase-align channels running D=4, 6, 10
    dch[0] = 4; dch[1] = 6; dch[2] = 10;
    load = 3'b111;
    div_i = {16'd10, 16'd6, 16'd4};
    step();
    load = 3'b000;
    for (int i = 0; i < 23; i++) step();
    en = 3'b011;
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    en = 3'b111;
    check("sync_clk", 32'(clk_o), 32'd0);
    check("sync_tick", 32'(tick_o), 32'd0);
    for (int e = 1; e <= 12; e++) begin
      step();
      for (int c = 0; c < 3; c++) begin
        k = e % dch[c];
        check($sformatf("sync_clk_ch%0d_%0d", c, e), 32'(clk_o[c]),
              (k >= dch[c] / 2) ? 32'd1 : 32'd0);
        check($sformatf("sync_tick_ch%0d_%0d", c, e), 32'(tick_o[c]),
              (k == dch[c] - 1) ? 32'd1 : 32'd0);
      end
    end
`else
    dch[0] = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
